// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect sequencing and operand forwarding for the
// 5-stage pipeline, driven from the ID-stage decode and an EX/MEM/WB shadow.
`default_nettype none

module hazard_ctrl #(
  parameter int RA_W    = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic             id_imm_b,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             id_wr_flags,
  input  logic             id_branch,
  input  logic [1:0]       id_cond,
  input  logic             id_jump,
  input  logic             id_call,
  input  logic             id_ret,
  input  logic             C,
  input  logic             Z,
  output logic             pc_writebar,
  output logic             IF_ID_loadbar,
  output logic             ID_EX_flush,
  output logic             flush,
  output logic [1:0]       pc_mux,
  output logic             push,
  output logic             pop,
  output logic [1:0]       forward_A,
  output logic [1:0]       forward_B,
  output logic [1:0]       forward_mem_EX,
  output logic             forward_mem_MEM,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
    logic            wr_flags;
  } ex_entry_t;

  // Flags are consumed while the producer sits in EX, so later stages drop wr_flags.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
  } late_entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  ex_entry_t   ex_q;
  late_entry_t mem_q, wb_q;
  state_t      state, state_nx;

  logic            fmm_ex_q, fmm_mem_q;
  logic [RA_W-1:0] fmm_rd_ex_q, fmm_rd_mem_q;

  function automatic logic hit(input logic v, input logic rw,
                               input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r);
    return v && rw && (rd == r) && !(R0_ZERO && (r == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit);
    if (ex_hit && !ex_ld) return 2'b10;
    if (mem_hit)          return 2'b11;
    return 2'b00;
  endfunction

  logic ex_hit_rs, ex_hit_rt, ex_hit_rd;
  logic mem_hit_rs, mem_hit_rt, mem_hit_rd;
  logic load_use, flag_haz, stall, taken, redirect;
  logic [1:0] fa_nx, fb_nx, fme_nx;
  logic fmm_nx;

  assign ex_hit_rs  = hit(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rs);
  assign ex_hit_rt  = hit(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rt);
  assign ex_hit_rd  = hit(ex_q.valid, ex_q.reg_write, ex_q.rd, id_rd);
  assign mem_hit_rs = hit(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rs);
  assign mem_hit_rt = hit(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rt);
  assign mem_hit_rd = hit(mem_q.valid, mem_q.reg_write, mem_q.rd, id_rd);

  // Store data matching a load in EX is covered by the WB->MEM path, so it never stalls.
  assign load_use = id_valid && ex_q.is_load &&
                    ((id_use_a && ex_hit_rs) || (id_use_b && !id_imm_b && ex_hit_rt));
  assign flag_haz = id_valid && id_branch && ex_q.valid && ex_q.wr_flags;
  assign stall    = (load_use || flag_haz) && !reset;

  always_comb begin
    taken = 1'b0;
    case (id_cond)
      2'b00:   taken = Z;
      2'b01:   taken = !Z;
      2'b10:   taken = C;
      default: taken = !C;
    endcase
  end

  assign fa_nx  = fwd_sel(ex_hit_rs, ex_q.is_load, mem_hit_rs);
  assign fb_nx  = id_imm_b ? 2'b01 : fwd_sel(ex_hit_rt, ex_q.is_load, mem_hit_rt);
  assign fme_nx = id_is_store ? fwd_sel(ex_hit_rd, ex_q.is_load, mem_hit_rd) : 2'b00;
  assign fmm_nx = id_valid && id_is_store && ex_q.is_load && ex_hit_rd;

  always_comb begin
    pc_writebar   = 1'b0;
    IF_ID_loadbar = 1'b0;
    ID_EX_flush   = 1'b0;
    flush         = 1'b0;
    pc_mux        = 2'b00;
    push          = 1'b0;
    pop           = 1'b0;
    if (stall) begin
      pc_writebar   = 1'b1;
      IF_ID_loadbar = 1'b1;
      ID_EX_flush   = 1'b1;
    end else if (id_valid && !reset) begin
      if (id_ret) begin
        pc_mux = 2'b11;
        pop    = 1'b1;
        flush  = 1'b1;
      end else if (id_call) begin
        pc_mux = 2'b10;
        push   = 1'b1;
        flush  = 1'b1;
      end else if (id_jump) begin
        pc_mux = 2'b10;
        flush  = 1'b1;
      end else if (id_branch && taken) begin
        pc_mux = 2'b01;
        flush  = 1'b1;
      end
    end
  end

  assign redirect = flush;

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN, S_STALL, S_REDIR: begin
        if (stall)         state_nx = S_STALL;
        else if (redirect) state_nx = S_REDIR;
        else               state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_RUN;
      ex_q            <= '0;
      mem_q           <= '0;
      wb_q            <= '0;
      forward_A       <= 2'b00;
      forward_B       <= 2'b00;
      forward_mem_EX  <= 2'b00;
      fmm_ex_q        <= 1'b0;
      fmm_mem_q       <= 1'b0;
      fmm_rd_ex_q     <= '0;
      fmm_rd_mem_q    <= '0;
      bubble_cnt      <= '0;
    end else begin
      state <= state_nx;
      if (id_valid && !stall)
        ex_q <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write,
                  is_load: id_is_load, wr_flags: id_wr_flags};
      else
        ex_q <= '0;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                 is_load: ex_q.is_load};
      wb_q  <= mem_q;
      if (stall) begin
        forward_A      <= 2'b00;
        forward_B      <= 2'b00;
        forward_mem_EX <= 2'b00;
        fmm_ex_q       <= 1'b0;
      end else begin
        forward_A      <= fa_nx;
        forward_B      <= fb_nx;
        forward_mem_EX <= fme_nx;
        fmm_ex_q       <= fmm_nx;
      end
      fmm_rd_ex_q  <= id_rd;
      fmm_mem_q    <= fmm_ex_q;
      fmm_rd_mem_q <= fmm_rd_ex_q;
      if (stall && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  // The store reaches MEM exactly when its producing load reaches WB.
  assign forward_mem_MEM = fmm_mem_q && wb_q.is_load &&
                           hit(wb_q.valid, wb_q.reg_write, wb_q.rd, fmm_rd_mem_q);

endmodule

`default_nettype wire
